// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: issues one RV32I load or store at a time to word-organised data memory,
// stalling the pipeline until the access completes or is rejected as misaligned/unsupported.
module lsu_mem_initiator #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     wd,
  output logic                  stall,
  output logic                  done,
  output logic                  fault,
  output logic [DATA_W-1:0]     rd,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic [3:0]            mem_wr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  state_t                  state_q, state_d;
  logic                    is_load_q, is_load_d;
  logic [2:0]              f3_q, f3_d;
  logic [1:0]              off_q, off_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    fault_q, fault_d;
  logic [DATA_W-1:0]       rd_q, rd_d;
  logic [DM_ADDRESS-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_re_q, mem_re_d;
  logic [3:0]              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;

  logic                    active;
  logic                    req_legal;
  logic [3:0]              st_lanes;
  logic [DATA_W-1:0]       st_data;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [DATA_W-1:0]       ld_data;
  logic                    unused_addr_hi;

  assign active         = req_valid & (MemRead | MemWrite);
  assign stall          = active & ~done_q;
  assign unused_addr_hi = ^addr[31:DM_ADDRESS];

  assign done      = done_q;
  assign fault     = fault_q;
  assign rd        = rd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

  // Stores only support 000/001/010; LBU/LHU exist only for loads.
  always_comb begin
    req_legal = 1'b0;
    case (Funct3)
      3'b000:  req_legal = 1'b1;
      3'b001:  req_legal = ~addr[0];
      3'b010:  req_legal = (addr[1:0] == 2'b00);
      3'b100:  req_legal = MemRead;
      3'b101:  req_legal = MemRead & ~addr[0];
      default: req_legal = 1'b0;
    endcase
  end

  always_comb begin
    st_lanes = 4'b1111;
    st_data  = wd;
    case (Funct3[1:0])
      2'b00: begin
        st_lanes = 4'b0001 << addr[1:0];
        st_data  = {4{wd[7:0]}};
      end
      2'b01: begin
        st_lanes = addr[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{wd[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    f3_d        = f3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    rd_d        = rd_q;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = 1'b0;
    mem_wr_d    = 4'b0000;
    mem_wdata_d = '0;

    case (state_q)
      IDLE: begin
        if (active) begin
          is_load_d = MemRead;
          f3_d      = Funct3;
          off_d     = addr[1:0];
          if (!req_legal) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d    = ISSUE;
            mem_addr_d = {addr[DM_ADDRESS-1:2], 2'b00};
            if (MemRead) begin
              mem_re_d = 1'b1;
            end else begin
              mem_wr_d    = st_lanes;
              mem_wdata_d = st_data;
            end
          end
        end
      end

      ISSUE: begin
        if (is_load_q && MEM_LATENCY > 1) begin
          state_d  = WAIT;
          cnt_d    = LAT_M1;
          mem_re_d = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          if (is_load_q) rd_d = ld_data;
        end
      end

      // Data is sampled at the end of the MEM_LATENCY-th read cycle.
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = DONE;
          done_d  = 1'b1;
          rd_d    = ld_data;
        end else begin
          mem_re_d = 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      cnt_q       <= 3'd0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rd_q        <= '0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_wr_q    <= 4'b0000;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      rd_q        <= rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: table vectors, corner sequences and random accesses vs a reference model.
module tb_lsu_mem_initiator;
  localparam int DM = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req_valid [2];
  logic          mem_read  [2];
  logic          mem_write [2];
  logic [2:0]    funct3    [2];
  logic [31:0]   addr      [2];
  logic [31:0]   wd        [2];
  logic [31:0]   mem_rdata [2];
  logic          stall     [2];
  logic          done      [2];
  logic          fault     [2];
  logic          mem_re    [2];
  logic [31:0]   rd        [2];
  logic [31:0]   mem_wdata [2];
  logic [DM-1:0] mem_addr  [2];
  logic [3:0]    mem_wr    [2];

  lsu_mem_initiator #(.DM_ADDRESS(DM), .DATA_W(32), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .MemRead(mem_read[0]),
    .MemWrite(mem_write[0]), .Funct3(funct3[0]), .addr(addr[0]), .wd(wd[0]),
    .stall(stall[0]), .done(done[0]), .fault(fault[0]), .rd(rd[0]),
    .mem_addr(mem_addr[0]), .mem_re(mem_re[0]), .mem_wr(mem_wr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

  lsu_mem_initiator #(.DM_ADDRESS(DM), .DATA_W(32), .MEM_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .MemRead(mem_read[1]),
    .MemWrite(mem_write[1]), .Funct3(funct3[1]), .addr(addr[1]), .wd(wd[1]),
    .stall(stall[1]), .done(done[1]), .fault(fault[1]), .rd(rd[1]),
    .mem_addr(mem_addr[1]), .mem_re(mem_re[1]), .mem_wr(mem_wr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

  typedef struct {
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] rdata;
  } acc_t;

  typedef struct {
    bit          fault;
    logic [3:0]  wr;
    logic [31:0] wdata;
    logic [8:0]  maddr;
    logic [31:0] rd;
  } exp_t;

  typedef struct {
    acc_t a;
    exp_t e;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] prev_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit ld, input bit st, input logic [2:0] f3,
                              input logic [31:0] ad, input logic [31:0] wdv,
                              input logic [31:0] rdata, input bit flt, input logic [3:0] wr,
                              input logic [31:0] wdata, input logic [8:0] ma,
                              input logic [31:0] r);
    vec_t v;
    v.a = '{ld, st, f3, ad, wdv, rdata};
    v.e = '{flt, wr, wdata, ma, r};
    return v;
  endfunction

  // Reference: access size from Funct3, legality by alignment, lanes/extension by arithmetic.
  function automatic exp_t model(input acc_t a, input logic [31:0] prv);
    exp_t   e;
    int     off;
    int     size;
    bit     ok;
    longint v;
    off  = int'(a.ad % 4);
    size = 1 << int'(a.f3 % 4);
    if (a.ld) ok = !(a.f3 == 3'd3 || a.f3 == 3'd6 || a.f3 == 3'd7);
    else      ok = (a.f3 < 3'd3);
    ok = ok && (off % size == 0);
    e.fault = !ok;
    e.wr    = 4'b0000;
    e.wdata = 32'h0;
    e.rd    = prv;
    e.maddr = 9'((a.ad % 512) / 4 * 4);
    if (ok && a.ld) begin
      v = (longint'(a.rdata) >> (8 * off)) % (longint'(1) << (8 * size));
      if (a.f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      e.rd = v[31:0];
    end else if (ok) begin
      e.wr = 4'(((1 << size) - 1) << off);
      case (size)
        1:       e.wdata = (a.wd % 256) * 32'h01010101;
        2:       e.wdata = (a.wd % 65536) * 32'h00010001;
        default: e.wdata = a.wd;
      endcase
    end
    return e;
  endfunction

  task automatic run_access(input int idx, input acc_t a, input exp_t e,
                            input bit drop_req, input bit scramble, input string tag);
    int          lat, exp_done, done_cyc, re_cnt, wr_cnt, addr_bad, stall_bad;
    logic [3:0]  wr_seen;
    logic [31:0] wdata_seen, rd_seen;
    logic        fault_seen;
    bit          exp_stall;
    lat        = (idx == 0) ? 1 : 3;
    exp_done   = e.fault ? 2 : (a.ld ? 2 + lat : 3);
    done_cyc   = 0;
    re_cnt     = 0;
    wr_cnt     = 0;
    addr_bad   = 0;
    stall_bad  = 0;
    wr_seen    = 4'b0000;
    wdata_seen = 32'h0;
    rd_seen    = 32'h0;
    fault_seen = 1'b0;
    @(posedge clk); #1;
    req_valid[idx] = 1'b1;
    mem_read[idx]  = a.ld;
    mem_write[idx] = a.st;
    funct3[idx]    = a.f3;
    addr[idx]      = a.ad;
    wd[idx]        = a.wd;
    mem_rdata[idx] = ~a.rdata;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      exp_stall = req_valid[idx] && (mem_read[idx] || mem_write[idx]) && (cyc != exp_done);
      if (stall[idx] !== exp_stall) stall_bad++;
      if (mem_re[idx] !== 1'b0) begin
        re_cnt++;
        if (mem_addr[idx] !== e.maddr) addr_bad++;
      end
      if (mem_wr[idx] !== 4'b0000) begin
        wr_cnt++;
        wr_seen    = mem_wr[idx];
        wdata_seen = mem_wdata[idx];
        if (mem_addr[idx] !== e.maddr) addr_bad++;
      end
      // Memory returns valid data only in the lat-th read cycle.
      mem_rdata[idx] = (mem_re[idx] === 1'b1 && re_cnt == lat) ? a.rdata : ~a.rdata;
      if (done[idx] === 1'b1) begin
        done_cyc   = cyc;
        fault_seen = fault[idx];
        rd_seen    = rd[idx];
        break;
      end
      @(posedge clk); #1;
      if (drop_req) req_valid[idx] = 1'b0;
      if (scramble) begin
        addr[idx]   = $urandom;
        funct3[idx] = 3'($urandom);
        wd[idx]     = $urandom;
      end
    end
    req_valid[idx] = 1'b0;
    check($sformatf("%s/done_cycle", tag), 32'(done_cyc), 32'(exp_done));
    check($sformatf("%s/fault", tag), 32'(fault_seen), 32'(e.fault));
    check($sformatf("%s/rd", tag), rd_seen, e.rd);
    check($sformatf("%s/re_cycles", tag), 32'(re_cnt), 32'((a.ld && !e.fault) ? lat : 0));
    check($sformatf("%s/wr_cycles", tag), 32'(wr_cnt), 32'((!a.ld && !e.fault) ? 1 : 0));
    check($sformatf("%s/mem_wr", tag), 32'(wr_seen), 32'(e.wr));
    check($sformatf("%s/mem_wdata", tag), wdata_seen, e.wdata);
    check($sformatf("%s/addr_errs", tag), 32'(addr_bad), 32'(0));
    check($sformatf("%s/stall_errs", tag), 32'(stall_bad), 32'(0));
  endtask

  vec_t tbl [18];

  initial begin
    acc_t a;
    exp_t e;

    tbl[0]  = mk(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,       0, 4'b1111, 32'hDEADBEEF, 9'h010, 32'h0);
    tbl[1]  = mk(0, 1, 3'b000, 32'h13,  32'h000000A5, 32'h0,       0, 4'b1000, 32'hA5A5A5A5, 9'h010, 32'h0);
    tbl[2]  = mk(0, 1, 3'b001, 32'h16,  32'hCAFE1234, 32'h0,       0, 4'b1100, 32'h12341234, 9'h014, 32'h0);
    tbl[3]  = mk(0, 1, 3'b000, 32'h01,  32'h1234565A, 32'h0,       0, 4'b0010, 32'h5A5A5A5A, 9'h000, 32'h0);
    tbl[4]  = mk(0, 1, 3'b001, 32'h04,  32'h0000BEEF, 32'h0,       0, 4'b0011, 32'hBEEFBEEF, 9'h004, 32'h0);
    tbl[5]  = mk(1, 0, 3'b000, 32'h03,  32'hFFFFFFFF, 32'h80F17F01, 0, 4'b0000, 32'h0, 9'h000, 32'hFFFFFF80);
    tbl[6]  = mk(1, 0, 3'b100, 32'h03,  32'hFFFFFFFF, 32'h80F17F01, 0, 4'b0000, 32'h0, 9'h000, 32'h00000080);
    tbl[7]  = mk(1, 0, 3'b001, 32'h00,  32'hFFFFFFFF, 32'h80F17F01, 0, 4'b0000, 32'h0, 9'h000, 32'h00007F01);
    tbl[8]  = mk(1, 0, 3'b101, 32'h02,  32'hFFFFFFFF, 32'h80F17F01, 0, 4'b0000, 32'h0, 9'h000, 32'h000080F1);
    tbl[9]  = mk(1, 0, 3'b010, 32'h22,  32'hFFFFFFFF, 32'h11111111, 1, 4'b0000, 32'h0, 9'h020, 32'h000080F1);
    tbl[10] = mk(0, 1, 3'b001, 32'h05,  32'h0000ABCD, 32'h0,       1, 4'b0000, 32'h0, 9'h004, 32'h000080F1);
    tbl[11] = mk(1, 0, 3'b011, 32'h00,  32'hFFFFFFFF, 32'h22222222, 1, 4'b0000, 32'h0, 9'h000, 32'h000080F1);
    tbl[12] = mk(0, 1, 3'b011, 32'h08,  32'h33333333, 32'h0,       1, 4'b0000, 32'h0, 9'h008, 32'h000080F1);
    tbl[13] = mk(1, 0, 3'b110, 32'h00,  32'hFFFFFFFF, 32'h44444444, 1, 4'b0000, 32'h0, 9'h000, 32'h000080F1);
    tbl[14] = mk(1, 0, 3'b010, 32'h1FC, 32'hFFFFFFFF, 32'h12345678, 0, 4'b0000, 32'h0, 9'h1FC, 32'h12345678);
    tbl[15] = mk(1, 0, 3'b010, 32'h204, 32'hFFFFFFFF, 32'h0BADF00D, 0, 4'b0000, 32'h0, 9'h004, 32'h0BADF00D);
    tbl[16] = mk(1, 1, 3'b001, 32'h02,  32'h55555555, 32'h80017F01, 0, 4'b0000, 32'h0, 9'h000, 32'hFFFF8001);
    tbl[17] = mk(1, 0, 3'b000, 32'h01,  32'hFFFFFFFF, 32'h00007F00, 0, 4'b0000, 32'h0, 9'h000, 32'h0000007F);

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      mem_read[i]  = 1'b0;
      mem_write[i] = 1'b0;
      funct3[i]    = 3'b000;
      addr[i]      = 32'h0;
      wd[i]        = 32'h0;
      mem_rdata[i] = 32'h0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset%0d/stall", i), 32'(stall[i]), 32'(0));
      check($sformatf("reset%0d/done", i), 32'(done[i]), 32'(0));
      check($sformatf("reset%0d/fault", i), 32'(fault[i]), 32'(0));
      check($sformatf("reset%0d/mem_re", i), 32'(mem_re[i]), 32'(0));
      check($sformatf("reset%0d/mem_wr", i), 32'(mem_wr[i]), 32'(0));
      check($sformatf("reset%0d/rd", i), rd[i], 32'h0);
      check($sformatf("reset%0d/mem_addr", i), 32'(mem_addr[i]), 32'(0));
      check($sformatf("reset%0d/mem_wdata", i), mem_wdata[i], 32'h0);
    end
    reset = 1'b0;

    for (int i = 0; i < 18; i++)
      run_access(0, tbl[i].a, tbl[i].e, 1'b0, (i % 2) == 1, $sformatf("vec%0d", i));

    // Three-cycle memory: LW keeps mem_re for 3 cycles, done 5 cycles after accept.
    a = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h13579BDF};
    run_access(1, a, '{1'b0, 4'b0000, 32'h0, 9'h020, 32'h13579BDF}, 1'b0, 1'b1, "lat3_lw");
    a = '{1'b1, 1'b0, 3'b000, 32'h21, 32'h0, 32'h00008000};
    run_access(1, a, '{1'b0, 4'b0000, 32'h0, 9'h020, 32'hFFFFFF80}, 1'b1, 1'b0, "lat3_lb_drop");
    a = '{1'b0, 1'b1, 3'b010, 32'h0C, 32'h76543210, 32'h0};
    run_access(0, a, '{1'b0, 4'b1111, 32'h76543210, 9'h00C, 32'h0000007F}, 1'b1, 1'b0, "sw_drop");

    // Reset landing on a store's ISSUE cycle must drop the write enables at once.
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    mem_read[0]  = 1'b0;
    mem_write[0] = 1'b1;
    funct3[0]    = 3'b010;
    addr[0]      = 32'h30;
    wd[0]        = 32'h11223344;
    @(posedge clk); #1;
    check("rst_mid/issue_wr", 32'(mem_wr[0]), 32'hF);
    #2;
    reset        = 1'b1;
    req_valid[0] = 1'b0;
    #1;
    check("rst_mid/mem_wr", 32'(mem_wr[0]), 32'(0));
    check("rst_mid/mem_wdata", mem_wdata[0], 32'h0);
    check("rst_mid/stall", 32'(stall[0]), 32'(0));
    check("rst_mid/done", 32'(done[0]), 32'(0));
    check("rst_mid/rd", rd[0], 32'h0);
    @(posedge clk); #1;
    check("rst_mid/mem_wr_held", 32'(mem_wr[0]), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    prev_rd[0] = 32'h0;
    prev_rd[1] = 32'h0;
    a = '{1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'hA1B2C3D4};
    e = model(a, prev_rd[0]);
    run_access(0, a, e, 1'b0, 1'b0, "post_rst_lw");
    check("post_rst/model_rd", e.rd, 32'hA1B2C3D4);
    prev_rd[0] = e.rd;

    for (int n = 0; n < 200; n++) begin
      int idx;
      int op;
      idx  = $urandom_range(0, 1);
      op   = $urandom_range(0, 3);
      a.ld = (op != 2);
      a.st = (op >= 2);
      a.f3 = 3'($urandom_range(0, 7));
      a.ad = $urandom;
      if ($urandom_range(0, 1) == 1) a.ad[1:0] = 2'b00;
      a.wd    = $urandom;
      a.rdata = $urandom;
      e = model(a, prev_rd[idx]);
      run_access(idx, a, e, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 $sformatf("rnd%0d", n));
      prev_rd[idx] = e.rd;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator between the pipeline MEM stage and the word-organised data memory.
- Accepts one load or store at a time from the pipeline and stalls the pipeline while the access is in flight.
- Stores: generates word-aligned addresses, byte-lane write enables and lane-shifted write data.
- Loads: extracts the addressed byte/half/word and sign- or zero-extends it per Funct3.
- Flags misaligned or unsupported accesses instead of issuing them to memory.

Parameters:
- DM_ADDRESS, 9, width of the byte address forwarded to data memory.
- DATA_W, 32, data width; fixed at 32 for RV32I.
- MEM_LATENCY, 1, cycles from read issue to valid mem_rdata; legal range 1..7.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  pipeline presents an access; held high until done.
- MemRead  input  1  load request from the control unit.
- MemWrite  input  1  store request from the control unit.
- Funct3  input  3  instruction bits 14:12.
- addr  input  32  byte address from the ALU.
- wd  input  DATA_W  store data (rs2).
- stall  output  1  freeze the pipeline.
- done  output  1  one-cycle completion pulse.
- fault  output  1  valid with done: misaligned or unsupported Funct3; no memory access was made.
- rd  output  DATA_W  extended load result; held until the next accept.
- mem_addr  output  DM_ADDRESS  word-aligned address, low 2 bits always 0.
- mem_re  output  1  read strobe.
- mem_wr  output  4  byte write enables; bit i enables lane i, little-endian.
- mem_wdata  output  DATA_W  lane-aligned write data.
- mem_rdata  input  DATA_W  memory read data.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset (asynchronous):
  - State returns to IDLE.
  - stall, done, fault, mem_re = 0; mem_wr = 4'b0000; rd, mem_addr, mem_wdata = 0.
  - Latency counter = 0.
  - An in-flight access is abandoned; no write enable may stay asserted.
- Operation is active when req_valid & (MemRead | MemWrite). MemRead has priority when both are high.
- stall = active & ~done, combinational.
- IDLE, active request: latch addr, Funct3, wd and the direction.
  - Legality check (see rules below); if illegal, go to DONE with fault=1.
  - Otherwise go to ISSUE.
- ISSUE, one cycle:
  - mem_addr = {addr[DM_ADDRESS-1:2], 2'b00}.
  - Load: mem_re = 1; counter loads MEM_LATENCY-1; go to WAIT, or to DONE when MEM_LATENCY = 1, sampling mem_rdata at the cycle end.
  - Store: mem_wr and mem_wdata asserted for exactly this cycle; go to DONE.
- WAIT: hold mem_addr and mem_re; decrement the counter; at 0 sample mem_rdata and go to DONE.
- DONE: done = 1 for one cycle; rd updated on loads only; go to IDLE.
  - A new request may be accepted from IDLE on the following cycle.
  - Back-to-back throughput is 3 cycles per access at MEM_LATENCY = 1.
- Store lanes:
  - SB (000): mem_wr = 1 << addr[1:0]; mem_wdata = {4{wd[7:0]}}.
  - SH (001): mem_wr = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{wd[15:0]}}.
  - SW (010): mem_wr = 4'b1111; mem_wdata = wd.
- Load extract: byte lane = addr[1:0], half lane = addr[1].
  - LB (000) sign-extends; LBU (100) zero-extends.
  - LH (001) sign-extends; LHU (101) zero-extends.
  - LW (010) passes the word through.
- Legality:
  - Halfword accesses require addr[0] = 0; word accesses require addr[1:0] = 0.
  - Unsupported Funct3: loads 011/110/111; stores other than 000/001/010.
  - Any illegal access gives fault = 1, mem_re/mem_wr never asserted, rd unchanged.
- Request changes (addr, Funct3, wd) after accept are ignored; the latched copies are used.
- If req_valid drops mid-operation, the access still completes and done still pulses.
- Address bits above DM_ADDRESS-1 are ignored (wrap within memory).

Test Plan:
- SW addr=0x10, wd=0xDEADBEEF -> one ISSUE cycle with mem_addr=0x10, mem_wr=1111, mem_wdata=0xDEADBEEF; done on cycle 3; stall high for cycles 1-2.
- SB addr=0x13, wd=0x000000A5 -> mem_wr=1000, mem_wdata=0xA5A5A5A5; SH addr=0x16 -> mem_wr=1100.
- mem_rdata=0x80F17F01: LB @0x3 -> rd=0xFFFFFF80; LBU @0x3 -> rd=0x00000080; LH @0x0 -> rd=0x00007F01; LHU @0x2 -> rd=0x000080F1.
- MEM_LATENCY=3, LW @0x20 -> mem_re high for 3 cycles with mem_addr=0x20; done on the 5th cycle after accept; rd=mem_rdata.
- LW @0x22, then SH @0x05, then load Funct3=011 -> each: done next cycle with fault=1; mem_re=0 and mem_wr=0000 throughout; rd unchanged.
- Assert reset during an SW ISSUE cycle -> mem_wr drops to 0000 immediately (asynchronous); state IDLE; stall=0; a following LW completes normally.
